pts_tx_ctrl: RTL and testbench

Transmit framing controller that sits directly upstream of flex_pts_sr, configured with SIZE = FRAME_BITS and MSB = 0.
- Accepts data words over a valid/ready handshake and holds them in a one-entry buffer.
- Frames each word with a start bit (0) and stop bit(s) (1).
- Drives the shift register's parallel_in, load_enable and shift_enable so the frame leaves LSB-first at one bit per BIT_PERIOD clocks.
- The serial line idles high.

---
 rtl/pts_tx_ctrl.sv | 119 +++++++++++
 tb/tb_pts_tx_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pts_tx_ctrl.sv
// Transmit framing controller feeding flex_pts_sr (SIZE = FRAME_BITS, MSB = 0).
// Buffers one word, frames it as {stop, data, start} and paces LSB-first shifting.
module pts_tx_ctrl #(
    parameter  int DATA_BITS  = 8,
    parameter  int BIT_PERIOD = 10,
    parameter  int STOP_BITS  = 1,
    localparam int FRAME_BITS = DATA_BITS + 1 + STOP_BITS
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [DATA_BITS-1:0]  tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [FRAME_BITS-1:0] pts_parallel_in,
    output logic                  pts_load_enable,
    output logic                  pts_shift_enable,
    output logic                  tx_busy,
    output logic                  frame_done
);

    localparam int TW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam int CW = $clog2(FRAME_BITS + 1);
    localparam logic [TW-1:0] T_LAST = TW'(BIT_PERIOD - 1);
    localparam logic [CW-1:0] C_LAST = CW'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND
    } state_t;

    state_t                state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  buf_valid;
    logic [DATA_BITS-1:0]  buf_data;
    logic                  buf_clr;
    logic                  load_d;
    logic                  shift_d;
    logic                  done_d;
    logic [FRAME_BITS-1:0] frame_d;

    assign tx_ready = !buf_valid;
    assign tx_busy  = buf_valid | (state_q != IDLE);

    // One-entry buffer; LOAD is the only state that clears it and tx_ready is low there.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            buf_valid <= 1'b0;
            buf_data  <= '0;
        end else if (buf_clr) begin
            buf_valid <= 1'b0;
        end else if (tx_valid && !buf_valid) begin
            buf_valid <= 1'b1;
            buf_data  <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_cnt_d = bit_cnt_q;
        buf_clr   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (buf_valid) state_d = LOAD;
            end
            LOAD: begin
                state_d   = SEND;
                timer_d   = '0;
                bit_cnt_d = '0;
                buf_clr   = 1'b1;
            end
            SEND: begin
                if (timer_q == T_LAST) begin
                    timer_d   = '0;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == C_LAST) state_d = buf_valid ? LOAD : IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are decoded from the next-state values.
        load_d  = (state_d == LOAD);
        shift_d = (state_d == SEND) && (timer_d == T_LAST);
        done_d  = shift_d && (bit_cnt_d == C_LAST);
        frame_d = load_d ? {{STOP_BITS{1'b1}}, buf_data, 1'b0} : '1;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pts_load_enable  <= 1'b0;
            pts_shift_enable <= 1'b0;
            frame_done       <= 1'b0;
            pts_parallel_in  <= '1;
        end else begin
            pts_load_enable  <= load_d;
            pts_shift_enable <= shift_d;
            frame_done       <= done_d;
            pts_parallel_in  <= frame_d;
        end
    end

endmodule

// File: tb/tb_pts_tx_ctrl.sv
// Bench for pts_tx_ctrl at BIT_PERIOD 4 and 2, with a timeline model of each frame
// and a behavioural LSB-first shift register standing in for flex_pts_sr.
module tb_pts_tx_ctrl;

    localparam int DB = 8;
    localparam int SB = 1;
    localparam int FB = DB + 1 + SB;
    localparam int NI = 2;
    localparam longint FAR = -1000000;

    logic          tb_clk   = 1'b0;
    logic          n_rst    = 1'b1;
    logic [DB-1:0] tx_data  = '0;
    logic          tx_valid = 1'b0;
    logic          chk_en   = 1'b0;

    logic [NI-1:0] rdy, load, shift, busy, done;
    logic [FB-1:0] pin [NI];
    logic [FB-1:0] sr  [NI];

    int checks   = 0;
    int failures = 0;

    pts_tx_ctrl #(.DATA_BITS(DB), .BIT_PERIOD(4), .STOP_BITS(SB)) u_dut0 (
        .clk(tb_clk), .n_rst(n_rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(rdy[0]), .pts_parallel_in(pin[0]), .pts_load_enable(load[0]),
        .pts_shift_enable(shift[0]), .tx_busy(busy[0]), .frame_done(done[0])
    );

    pts_tx_ctrl #(.DATA_BITS(DB), .BIT_PERIOD(2), .STOP_BITS(SB)) u_dut1 (
        .clk(tb_clk), .n_rst(n_rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(rdy[1]), .pts_parallel_in(pin[1]), .pts_load_enable(load[1]),
        .pts_shift_enable(shift[1]), .tx_busy(busy[1]), .frame_done(done[1])
    );

    always #5 tb_clk = ~tb_clk;

    function automatic int bp_of(input int i);
        return (i == 0) ? 4 : 2;
    endfunction

    function automatic logic [FB-1:0] framed(input logic [DB-1:0] d);
        return {{SB{1'b1}}, d, 1'b0};
    endfunction

    task automatic chk(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] actual=%0h required=%0h", name, inst, act, exp);
        end
    endtask

    // Downstream shift register: parallel load, shift right with 1 fill, serial out = bit 0.
    always_ff @(posedge tb_clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < NI; i++) sr[i] <= '1;
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (load[i])       sr[i] <= pin[i];
                else if (shift[i]) sr[i] <= {1'b1, sr[i][FB-1:1]};
            end
        end
    end

    // Timeline model: s[i] is the cycle of the most recent load strobe; everything
    // else is derived from the distance of the current cycle to it.
    longint        cyc;
    logic          bv [NI];
    logic [DB-1:0] bd [NI];
    logic [DB-1:0] fd [NI];
    longint        s  [NI];
    logic          m_pre_bv;
    logic [DB-1:0] m_pre_bd;
    longint        m_w;

    always @(posedge tb_clk or negedge n_rst) begin
        if (!n_rst) begin
            cyc = 0;
            for (int i = 0; i < NI; i++) begin
                bv[i] = 1'b0; bd[i] = '0; fd[i] = '0; s[i] = FAR;
            end
        end else begin
            cyc = cyc + 1;
            for (int i = 0; i < NI; i++) begin
                m_w      = longint'(FB * bp_of(i));
                m_pre_bv = bv[i];
                m_pre_bd = bd[i];
                if (m_pre_bv && cyc == s[i] + 1) bv[i] = 1'b0;
                if (tx_valid && !m_pre_bv) begin
                    bv[i] = 1'b1;
                    bd[i] = tx_data;
                end
                if (m_pre_bv && cyc > s[i] + m_w) begin
                    s[i]  = cyc;
                    fd[i] = m_pre_bd;
                end
            end
        end
    end

    longint        c_d, c_w;
    int            c_b;
    logic          e_load, e_shift, e_done, e_busy, e_ser;
    logic [FB-1:0] e_pin, e_fr;

    always @(negedge tb_clk) begin
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                c_b     = bp_of(i);
                c_w     = longint'(FB * c_b);
                c_d     = cyc - s[i];
                e_load  = (c_d == 0);
                e_pin   = e_load ? framed(fd[i]) : '1;
                e_shift = (c_d > 0) && (c_d <= c_w) && (c_d % c_b == 0);
                e_done  = (c_d == c_w);
                e_busy  = bv[i] || (c_d <= c_w);
                e_fr    = framed(fd[i]);
                e_ser   = 1'b1;
                if (c_d >= 1 && (c_d - 1) / c_b < FB) e_ser = e_fr[int'((c_d - 1) / c_b)];
                chk("tx_ready", i, 32'(rdy[i]), 32'(!bv[i]));
                chk("tx_busy", i, 32'(busy[i]), 32'(e_busy));
                chk("load_enable", i, 32'(load[i]), 32'(e_load));
                chk("shift_enable", i, 32'(shift[i]), 32'(e_shift));
                chk("frame_done", i, 32'(done[i]), 32'(e_done));
                chk("parallel_in", i, 32'(pin[i]), 32'(e_pin));
                chk("serial_out", i, 32'(sr[i][0]), 32'(e_ser));
                chk("load_and_shift", i, 32'(load[i] & shift[i]), 32'd0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge tb_clk);
    endtask

    task automatic send(input logic [DB-1:0] d);
        int t;
        t = 0;
        while (!rdy[0] && t < 200) begin
            @(negedge tb_clk);
            t++;
        end
        if (!rdy[0]) chk("send_timeout", 0, 32'd0, 32'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge tb_clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_load();
        int t;
        t = 0;
        while (!load[0] && t < 200) begin
            @(negedge tb_clk);
            t++;
        end
        if (!load[0]) chk("load_timeout", 0, 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((busy != '0) && t < 600) begin
            @(negedge tb_clk);
            t++;
        end
        if (busy != '0) chk("idle_timeout", 0, 32'(busy), 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        for (int i = 0; i < NI; i++) begin
            chk({tag, "_ready"}, i, 32'(rdy[i]), 32'd1);
            chk({tag, "_busy"}, i, 32'(busy[i]), 32'd0);
            chk({tag, "_enables"}, i, 32'({load[i], shift[i], done[i]}), 32'd0);
            chk({tag, "_pin"}, i, 32'(pin[i]), 32'h3FF);
            chk({tag, "_serial"}, i, 32'(sr[i][0]), 32'd1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    logic [FB-1:0] a5_seq;
    int            done_at, ndone, run, nshift;

    initial begin
        // Reset with a valid word presented
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        #1 n_rst = 1'b0;
        tick(2);
        chk_reset_vals("reset");
        chk_en   = 1'b1;
        tx_valid = 1'b0;
        @(negedge tb_clk);
        n_rst = 1'b1;
        tick(2);

        // Single word 0xA5
        a5_seq = 10'b11_0100_1010;
        send(8'hA5);
        wait_load();
        chk("a5_pin", 0, 32'(pin[0]), 32'h34A);
        done_at = 0;
        ndone   = 0;
        for (int k = 1; k <= 44; k++) begin
            @(negedge tb_clk);
            if (k <= 40) chk("a5_serial", k, 32'(sr[0][0]), 32'(a5_seq[(k - 1) / 4]));
            if (done[0]) begin
                done_at = k;
                ndone++;
            end
        end
        chk("a5_done_at", 0, 32'(done_at), 32'd40);
        chk("a5_done_count", 0, 32'(ndone), 32'd1);
        chk("a5_busy_after", 0, 32'(busy[0]), 32'd0);
        wait_idle();

        // Back-to-back 0x00 then 0xFF
        send(8'h00);
        chk("b2b_ready_buffered", 0, 32'(rdy[0]), 32'd0);
        wait_load();
        chk("b2b_ready_in_load", 0, 32'(rdy[0]), 32'd0);
        tick(1);
        chk("b2b_ready_after_load", 0, 32'(rdy[0]), 32'd1);
        send(8'hFF);
        run = 0;
        for (int t = 0; t < 200 && !done[0]; t++) begin
            @(negedge tb_clk);
            run = sr[0][0] ? run + 1 : 0;
        end
        chk("b2b_first_done", 0, 32'(done[0]), 32'd1);
        tick(1);
        run = sr[0][0] ? run + 1 : 0;
        chk("b2b_second_load", 0, 32'(load[0]), 32'd1);
        chk("b2b_second_pin", 0, 32'(pin[0]), 32'h3FE);
        tick(1);
        chk("b2b_stop_len", 0, 32'(run), 32'd5);
        chk("b2b_start_bit", 0, 32'(sr[0][0]), 32'd0);
        tick(4);
        chk("b2b_data0", 0, 32'(sr[0][0]), 32'd1);
        wait_idle();

        // Buffer full: a held tx_valid must not overwrite the buffered word
        send(8'h11);
        wait_load();
        tick(1);
        tx_data  = 8'h22;
        tx_valid = 1'b1;
        @(negedge tb_clk);
        tx_data = 8'h99;
        wait_load();
        chk("no_overwrite_pin", 0, 32'(pin[0]), 32'h244);
        tick(2);
        tx_valid = 1'b0;
        wait_idle();

        // Reset during the 4th data bit of 0x3C
        send(8'h3C);
        wait_load();
        tick(18);
        #2 n_rst = 1'b0;
        #1 chk_reset_vals("midreset");
        @(negedge tb_clk);
        @(negedge tb_clk);
        n_rst  = 1'b1;
        nshift = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge tb_clk);
            nshift += int'(shift[0]) + int'(shift[1]) + int'(load[0]) + int'(load[1]);
        end
        chk("post_reset_activity", 0, 32'(nshift), 32'd0);
        send(8'h81);
        wait_load();
        chk("after_reset_pin", 0, 32'(pin[0]), 32'h302);
        wait_idle();

        // Randomised traffic with one asynchronous reset in the middle
        for (int k = 0; k < 4000; k++) begin
            @(negedge tb_clk);
            tx_valid = ($urandom_range(0, 3) == 0);
            tx_data  = DB'($urandom);
            if (k == 2000) begin
                #2 n_rst = 1'b0;
                @(negedge tb_clk);
                n_rst = 1'b1;
            end
        end
        @(negedge tb_clk);
        tx_valid = 1'b0;
        wait_idle();
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
